cpu_control_fsm: RTL and testbench

CPU_CONTROL_FSM -- requirements
Module: cpu_control_fsm

---
 rtl/cpu_control_fsm.sv | 208 ++++++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC(/LOADWB) sequencer driving a 16-bit datapath.
// Optional JAL (op 0x4, ext 0x8) is enabled by defining CPU_CTRL_JAL_EN.
//
// state  | meaning
// FETCH  | present pc on BRAM address, no strobes
// DECODE | BRAM data valid, latch into IR
// EXEC   | execute IR; branches/ALU/store complete here
// LOADWB | load data on bus, write back to register bank
module cpu_control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic [4:0]  flags,
  input  logic [15:0] reg_a_data,
  input  logic [15:0] reg_b_data,
  output logic [3:0]  a_sel,
  output logic [3:0]  b_sel,
  output logic        reg_wen,
  output logic [3:0]  reg_dest,
  output logic [15:0] imm,
  output logic        imm_sel,
  output logic [7:0]  alu_op,
  output logic        flags_en,
  output logic        alu_to_bus,
  output logic        mem_to_bus,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  output logic [15:0] pc
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_LOADWB = 2'd3
  } state_t;

  state_t      state_q;
  logic [15:0] pc_q;
  logic [15:0] ir_q;

  logic [3:0]  op, rd, ext, rs;
  logic [15:0] imm_sext;
  logic [3:0]  alu_code;
  logic        is_r_legal, is_i, is_alu, is_cmp, is_flag_op;
  logic        is_load, is_stor, is_jal, is_br, br_taken;
  logic        flag_c, flag_z, flag_n;
  logic        unused_flags;

  assign op       = ir_q[15:12];
  assign rd       = ir_q[11:8];
  assign ext      = ir_q[7:4];
  assign rs       = ir_q[3:0];
  assign imm_sext = {{8{ir_q[7]}}, ir_q[7:0]};

  assign flag_c       = flags[0];
  assign flag_z       = flags[3];
  assign flag_n       = flags[4];
  assign unused_flags = ^flags[2:1];

  always_comb begin
    is_r_legal = 1'b0;
    if (op == 4'h0) begin
      case (ext)
        4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD: is_r_legal = 1'b1;
        default:                                  is_r_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (op)
      4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD: is_i = 1'b1;
      default:                                  is_i = 1'b0;
    endcase
  end

  assign is_alu     = is_r_legal | is_i;
  assign alu_code   = (op == 4'h0) ? ext : op;
  assign is_cmp     = (alu_code == 4'hB);
  assign is_flag_op = (alu_code == 4'h5) | (alu_code == 4'h9) | (alu_code == 4'hB);
  assign is_load    = (op == 4'h4) && (ext == 4'h0);
  assign is_stor    = (op == 4'h4) && (ext == 4'h4);
  assign is_br      = (op == 4'hC);

`ifdef CPU_CTRL_JAL_EN
  assign is_jal = (op == 4'h4) && (ext == 4'h8);
`else
  assign is_jal = 1'b0;
`endif

  // Branch condition code lives in the rd field.
  always_comb begin
    case (rd)
      4'h0:    br_taken = flag_z;
      4'h1:    br_taken = ~flag_z;
      4'h2:    br_taken = flag_c;
      4'h3:    br_taken = ~flag_c;
      4'h6:    br_taken = flag_n;
      4'h7:    br_taken = ~flag_n;
      4'hE:    br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= 16'h0000;
      ir_q    <= 16'h0000;
    end else begin
      case (state_q)
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: begin
          ir_q    <= instr;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (is_load) begin
            state_q <= S_LOADWB;
          end else begin
            state_q <= S_FETCH;
            if (is_br && br_taken) pc_q <= pc_q + imm_sext;
            else if (is_jal)       pc_q <= reg_a_data;
            else                   pc_q <= pc_q + 16'd1;
          end
        end
        S_LOADWB: begin
          state_q <= S_FETCH;
          pc_q    <= pc_q + 16'd1;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    a_sel      = 4'h0;
    b_sel      = 4'h0;
    reg_wen    = 1'b0;
    reg_dest   = 4'h0;
    imm        = 16'h0000;
    imm_sel    = 1'b0;
    alu_op     = 8'h00;
    flags_en   = 1'b0;
    alu_to_bus = 1'b0;
    mem_to_bus = 1'b0;
    mem_addr   = pc_q;
    mem_we     = 1'b0;
    mem_wdata  = 16'h0000;
    case (state_q)
      S_EXEC: begin
        if (is_alu) begin
          a_sel  = rd;
          alu_op = {4'h0, alu_code};
          if (op == 4'h0) begin
            b_sel = rs;
          end else begin
            imm_sel = 1'b1;
            imm     = (op == 4'hD) ? {8'h00, ir_q[7:0]} : imm_sext;
          end
          if (!is_cmp) begin
            reg_wen    = 1'b1;
            alu_to_bus = 1'b1;
            reg_dest   = rd;
          end
          flags_en = is_flag_op;
        end else if (is_load) begin
          a_sel    = rs;
          mem_addr = reg_a_data;
        end else if (is_stor) begin
          a_sel     = rs;
          b_sel     = rd;
          mem_addr  = reg_a_data;
          mem_wdata = reg_b_data;
          mem_we    = 1'b1;
        end else if (is_jal) begin
          // Link value travels through the ALU as a MOV of the immediate.
          a_sel      = rs;
          imm        = pc_q + 16'd1;
          imm_sel    = 1'b1;
          alu_op     = 8'h0D;
          reg_wen    = 1'b1;
          reg_dest   = rd;
          alu_to_bus = 1'b1;
        end
      end
      S_LOADWB: begin
        a_sel      = rs;
        mem_addr   = reg_a_data;
        mem_to_bus = 1'b1;
        reg_wen    = 1'b1;
        reg_dest   = rd;
      end
      default: ;
    endcase
    // A reset cycle aborts the instruction, so no state-changing strobe may escape.
    if (reset) begin
      reg_wen  = 1'b0;
      flags_en = 1'b0;
      mem_we   = 1'b0;
    end
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: stimulus queues per-cycle expectations, a monitor pops and compares.
module tb_cpu_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic [4:0]  flags;
  logic [15:0] reg_a_data, reg_b_data;
  logic [3:0]  a_sel, b_sel, reg_dest;
  logic        reg_wen, imm_sel, flags_en, alu_to_bus, mem_to_bus, mem_we;
  logic [15:0] imm, mem_addr, mem_wdata, pc;
  logic [7:0]  alu_op;

  always #5 clk = ~clk;

  cpu_control_fsm dut (
    .clk(clk), .reset(reset), .instr(instr), .flags(flags),
    .reg_a_data(reg_a_data), .reg_b_data(reg_b_data),
    .a_sel(a_sel), .b_sel(b_sel), .reg_wen(reg_wen), .reg_dest(reg_dest),
    .imm(imm), .imm_sel(imm_sel), .alu_op(alu_op), .flags_en(flags_en),
    .alu_to_bus(alu_to_bus), .mem_to_bus(mem_to_bus), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .pc(pc)
  );

  typedef struct packed {
    logic [3:0]  a_sel;
    logic [3:0]  b_sel;
    logic        reg_wen;
    logic [3:0]  reg_dest;
    logic [15:0] imm;
    logic        imm_sel;
    logic [7:0]  alu_op;
    logic        flags_en;
    logic        alu_to_bus;
    logic        mem_to_bus;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] pc;
  } outs_t;

  typedef struct {
    string name;
    outs_t e;
    outs_t m;
  } exp_t;

  exp_t  sb[$];
  outs_t e, m, act;
  int    total = 0;
  int    bad = 0;
  logic [15:0] p;

  assign act = {a_sel, b_sel, reg_wen, reg_dest, imm, imm_sel, alu_op, flags_en,
                alu_to_bus, mem_to_bus, mem_addr, mem_we, mem_wdata, pc};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string nm);
    exp_t x;
    x.name = nm;
    x.e = e;
    x.m = m;
    sb.push_back(x);
  endtask

  // Every cycle: strobes default to 0 and pc is checked.
  task automatic clr(input logic [15:0] pv);
    e = '0;
    m = '0;
    m.reg_wen = '1; m.flags_en = '1; m.mem_we = '1; m.alu_to_bus = '1; m.mem_to_bus = '1;
    e.pc = pv; m.pc = '1;
  endtask

  task automatic fetch_decode(input logic [15:0] w, input logic [15:0] pv);
    step();
    reset = 1'b0;
    clr(pv); e.mem_addr = pv; m.mem_addr = '1;
    push("fetch");
    step();
    instr = w;
    clr(pv);
    push("decode");
  endtask

  // Leaves e/m primed for the EXEC cycle; caller adds fields and pushes.
  task automatic exec(input logic [15:0] w, input logic [15:0] pv, input logic [4:0] fl,
                      input logic [15:0] ra, input logic [15:0] rb);
    fetch_decode(w, pv);
    step();
    flags = fl; reg_a_data = ra; reg_b_data = rb;
    clr(pv);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        total++;
        if (((act ^ x.e) & x.m) != '0) begin
          bad++;
          $display("FAIL %s: got=%h exp=%h mask=%h", x.name, act, x.e, x.m);
        end
        total++;
        if (alu_to_bus && mem_to_bus) begin
          bad++;
          $display("FAIL bus_excl(%s): alu_to_bus=%b mem_to_bus=%b required not both 1",
                   x.name, alu_to_bus, mem_to_bus);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset = 1'b1; instr = 16'h0000; flags = 5'h00; reg_a_data = 16'h0000; reg_b_data = 16'h0000;
    step(); step();
    clr(16'h0000); e.mem_addr = 16'h0000; m.mem_addr = '1; m.imm = '1; m.alu_op = '1;
    push("reset");

    // MOVI r1,#7: zero-extended immediate, no flags
    exec(16'hD107, 16'h0000, 5'h00, 16'h0000, 16'h0000);
    e.reg_wen = 1; e.reg_dest = 4'h1; e.imm = 16'h0007; e.imm_sel = 1; e.alu_to_bus = 1;
    e.alu_op = 8'h0D; e.a_sel = 4'h1;
    m.reg_dest = '1; m.imm = '1; m.imm_sel = '1; m.alu_op = '1; m.a_sel = '1;
    push("movi");

    // ADD r1,r2
    exec(16'h0152, 16'h0001, 5'h00, 16'h0000, 16'h0000);
    e.a_sel = 4'h1; e.b_sel = 4'h2; e.alu_op = 8'h05; e.reg_wen = 1; e.flags_en = 1;
    e.alu_to_bus = 1; e.reg_dest = 4'h1; e.imm_sel = 0;
    m.a_sel = '1; m.b_sel = '1; m.alu_op = '1; m.reg_dest = '1; m.imm_sel = '1;
    push("add");

    // CMP r1,r2: flags only, no write
    exec(16'h01B2, 16'h0002, 5'h00, 16'h0000, 16'h0000);
    e.a_sel = 4'h1; e.b_sel = 4'h2; e.alu_op = 8'h0B; e.flags_en = 1;
    m.a_sel = '1; m.b_sel = '1; m.alu_op = '1;
    push("cmp");

    // SUBI r3,#-2: sign-extended
    exec(16'h93FE, 16'h0003, 5'h00, 16'h0000, 16'h0000);
    e.a_sel = 4'h3; e.imm = 16'hFFFE; e.imm_sel = 1; e.alu_op = 8'h09; e.reg_wen = 1;
    e.reg_dest = 4'h3; e.flags_en = 1; e.alu_to_bus = 1;
    m.a_sel = '1; m.imm = '1; m.imm_sel = '1; m.alu_op = '1; m.reg_dest = '1;
    push("subi");

    // Illegal R ext 4 -> NOP
    exec(16'h0144, 16'h0004, 5'h00, 16'h0000, 16'h0000);
    e.imm_sel = 0; m.imm_sel = '1;
    push("illegal_r");

    // op 0x4 ext 0x8: JAL when enabled, NOP otherwise
    exec(16'h4F86, 16'h0005, 5'h00, 16'h0100, 16'h0000);
`ifdef CPU_CTRL_JAL_EN
    e.reg_wen = 1; e.reg_dest = 4'hF; e.imm = 16'h0006; e.imm_sel = 1; e.alu_op = 8'h0D;
    e.a_sel = 4'h6; e.alu_to_bus = 1;
    m.reg_dest = '1; m.imm = '1; m.imm_sel = '1; m.alu_op = '1; m.a_sel = '1;
    push("jal");
    p = 16'h0100;
`else
    push("jal_nop");
    p = 16'h0006;
`endif

    // STOR: one-cycle mem_we, next fetch checks it dropped
    exec(16'h4443, p, 5'h00, 16'h0080, 16'hBEEF);
    e.a_sel = 4'h3; e.b_sel = 4'h4; e.mem_addr = 16'h0080; e.mem_wdata = 16'hBEEF; e.mem_we = 1;
    m.a_sel = '1; m.b_sel = '1; m.mem_addr = '1; m.mem_wdata = '1;
    push("stor");
    p = p + 16'd1;

    // LOAD r3,[r3]: EXEC addresses memory, LOADWB writes back
    exec(16'h4303, p, 5'h00, 16'h0040, 16'h0000);
    e.a_sel = 4'h3; e.mem_addr = 16'h0040;
    m.a_sel = '1; m.mem_addr = '1;
    push("load_exec");
    step();
    clr(p); e.mem_to_bus = 1; e.reg_wen = 1; e.reg_dest = 4'h3; m.reg_dest = '1;
    push("loadwb");
    p = p + 16'd1;

    // LOAD aborted by reset in LOADWB
    exec(16'h4303, p, 5'h00, 16'h0040, 16'h0000);
    e.a_sel = 4'h3; e.mem_addr = 16'h0040; m.a_sel = '1; m.mem_addr = '1;
    push("load_exec2");
    step();
    reset = 1'b1;
    clr(p); m.mem_to_bus = '0; m.alu_to_bus = '0;
    push("loadwb_reset");

    // Branches (exec cycle: no strobes); next fetch checks the new pc
    exec(16'hCE10, 16'h0000, 5'h00, 16'h0000, 16'h0000); push("b_uc");
    exec(16'hC0FE, 16'h0010, 5'b01000, 16'h0000, 16'h0000); push("beq_taken");
    exec(16'hC102, 16'h000E, 5'b00000, 16'h0000, 16'h0000); push("bne_taken");
    exec(16'hC0FE, 16'h0010, 5'b00000, 16'h0000, 16'h0000); push("beq_not");
    exec(16'hC205, 16'h0011, 5'b00000, 16'h0000, 16'h0000); push("bcs_not");
    exec(16'hC405, 16'h0012, 5'b11111, 16'h0000, 16'h0000); push("bcond_undef");
    exec(16'hCEE0, 16'h0013, 5'b00000, 16'h0000, 16'h0000); push("b_back_wrap");
    exec(16'hCE0C, 16'hFFF3, 5'b00000, 16'h0000, 16'h0000); push("b_to_ffff");
    exec(16'h6000, 16'hFFFF, 5'b00000, 16'h0000, 16'h0000); push("nop_wrap");
    exec(16'hC603, 16'h0000, 5'b10000, 16'h0000, 16'h0000); push("bgt_taken");
    fetch_decode(16'h0000, 16'h0003);

    repeat (4) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
